bcd_digit_converter: RTL
========================

// Module: bcd_digit_converter
// PURPOSE
//  Multi-cycle binary-to-BCD converter that uses the shift-add-3 (double-dabble) method.
//  It sits directly upstream of the seven-segment display controller.
//  It turns a binary counter or timer value into packed decimal digits plus a leading-zero blank mask.
//  This removes the divide/modulo chains from the display stage.
//  It uses one iteration per input bit and registers its outputs, which hold until the next conversion.
// PARAMETERS
//  BIN_W   16  width of the binary input, in bits (>=4)
//  DIGITS  5   number of BCD digits produced (>=1)
// PORTS
//  clock_100Mhz  in   1           system clock; all logic is on the rising edge
//  reset_n       in   1           asynchronous, active-low reset
//  start         in   1           request a conversion of bin_in; sampled only in IDLE
//  bin_in        in   BIN_W       unsigned value; captured on the cycle start is accepted
//  busy          out  1           high from the cycle after acceptance until the done cycle, inclusive
//  done          out  1           single-cycle pulse; bcd_out/blank/overflow are valid from this cycle
//  bcd_out       out  4*DIGITS    packed digits; [3:0] is the ones digit, [4*DIGITS-1:4*DIGITS-4] is the MSD
//  blank         out  DIGITS      bit i=1 means digit i is a leading zero; bit 0 is always 0
//  overflow      out  1           value exceeded 10^DIGITS-1; bcd_out saturated to all 9s
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, bcd_out=0, blank={DIGITS-1{1},1'b0}, overflow=0.
//    All internal registers are cleared.
//  States: IDLE -> SHIFT -> FINISH -> IDLE.
//  IDLE:
//    - start=1: load shift reg = bin_in, BCD accumulator = 0, iteration count = BIN_W-1; go to SHIFT.
//    - start=0: remain in IDLE.
//  SHIFT: runs exactly BIN_W cycles. Each cycle:
//    - Every accumulator digit >=5 gets +3 (each digit handled independently, 4-bit result).
//    - Then {acc, shift reg} shifts left by 1.
//    - A 1 shifted out of the accumulator MSB sets the sticky ovf flag.
//    - When the count reaches 0, go to FINISH; otherwise decrement the count.
//  FINISH (1 cycle):
//    - done=1.
//    - bcd_out = acc, or all 4'h9 if ovf.
//    - overflow = ovf.
//    - blank computed from the MSD downward: a digit is blank while it and every higher digit are 0.
//      Digit 0 is never blank. When overflow=1, blank = 0.
//    - Go to IDLE.
//  Latency: start accepted at edge N -> done high in cycle N+BIN_W+1.
//    Next start can be accepted at edge N+BIN_W+2.
//  busy: goes high on the edge that accepts start and drops on the edge leaving FINISH.
//  start while busy (SHIFT or FINISH): ignored. It is not queued and bin_in is not resampled.
//  start held high continuously: back-to-back conversions, one per BIN_W+2 cycles.
//  bcd_out, blank and overflow change only in FINISH; they are stable across IDLE and SHIFT.
//  Reset asserted mid-conversion:
//    - Immediate return to IDLE, all outputs at reset values.
//    - No done pulse for the aborted conversion.
//  Width rules: the accumulator is exactly 4*DIGITS bits.
//    The iteration counter is $clog2(BIN_W) bits and never wraps.
//  bin_in=0: bcd_out=0, blank={DIGITS-1{1},0}, overflow=0.
// TESTING
//  1) Default params; start with bin_in=0
//     -> done in cycle N+17; bcd_out=20'h00000; blank=5'b11110; overflow=0.
//  2) bin_in=16'd65535 -> bcd_out=20'h65535, blank=5'b00000, overflow=0;
//     bin_in=16'd1234 -> bcd_out=20'h01234, blank=5'b10000.
//  3) Accept bin_in=16'd42; pulse start with bin_in=16'd999 at cycles N+3 and N+17
//     -> exactly one done; result 20'h00042; busy never drops early.
//  4) DIGITS=4 with bin_in=16'd12345 -> overflow=1, bcd_out=16'h9999, blank=4'b0000;
//     then 16'd9999 -> overflow=0, 16'h9999.
//  5) Deassert reset_n at cycle N+8 of a conversion of 16'd500
//     -> busy=0, bcd_out=0 at once; no done. A fresh start afterwards gives 20'h00500.
//  6) start held high with bin_in stepping 30,29,28 -> done every 18 cycles;
//     results 20'h00030, 20'h00029, 20'h00028, blank=5'b11100.

Source files
------------

// File: rtl/bcd_digit_converter_if.sv
// Request/result bundle for the binary-to-BCD converter; the master drives start/bin_in,
// the slave returns busy, the done pulse and the registered result (start while busy is dropped).
interface bcd_digit_converter_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, overflow
    );
endinterface

// File: rtl/bcd_digit_converter.sv
// Double-dabble binary-to-BCD converter: one shift per input bit, done BIN_W+1 cycles after accept.
// No backpressure: start is only honoured in IDLE; results hold until the next conversion finishes.
module bcd_digit_converter #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset_n,
    bcd_digit_converter_if.slave  bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   sr;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;

    logic [ACC_W-1:0]   adj;
    logic [ACC_W-1:0]   acc_sh;
    logic [BIN_W-1:0]   sr_sh;
    logic               ovf_nxt;
    logic [ACC_W-1:0]   fin_bcd;
    logic [DIGITS-1:0]  fin_blank;
    logic               run;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        // Any 1 pushed past the top digit means the value cannot fit in DIGITS decimal places.
        ovf_nxt = ovf | adj[ACC_W-1];
        acc_sh  = {adj[ACC_W-2:0], sr[BIN_W-1]};
        sr_sh   = {sr[BIN_W-2:0], 1'b0};

        fin_bcd   = ovf_nxt ? {DIGITS{4'h9}} : acc_sh;
        fin_blank = '0;
        run       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run & (acc_sh[4*i +: 4] == 4'd0);
            fin_blank[i] = run & (i != 0) & ~ovf_nxt;
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sr           <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd_out  <= '0;
            bus.blank    <= BLANK_RST;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sr       <= bus.bin_in;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= CNT_W'(BIN_W - 1);
                        bus.busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr  <= sr_sh;
                    acc <= acc_sh;
                    ovf <= ovf_nxt;
                    if (cnt == '0) begin
                        bus.done     <= 1'b1;
                        bus.bcd_out  <= fin_bcd;
                        bus.blank    <= fin_blank;
                        bus.overflow <= ovf_nxt;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FINISH: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
